// File: rtl/tx_frame_packer.sv
`default_nettype none
// ============================================================================
// Module  : tx_frame_packer
// Purpose : FIFO-buffered DAC vector streamer with per-block Q1.7 gain.
//           Optional macro TX_UNDERFLOW_COUNT_EN adds a saturating underflow_count.
// Revision: 1.0  initial release
// ============================================================================
module tx_frame_packer #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int PRIME_LEVEL    = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [16*NUMBER_OF_LINE-1:0]   s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           tx_enable,
  input  logic [7:0]                     gain,
  output logic [16*NUMBER_OF_LINE-1:0]   dac_data,
  output logic                           dac_valid,
  output logic                           tx_active,
  output logic                           underflow,
`ifdef TX_UNDERFLOW_COUNT_EN
  output logic [15:0]                    underflow_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]    fill_level
);

  localparam int C_AW    = $clog2(FIFO_DEPTH);
  localparam int C_CW    = C_AW + 1;
  localparam int C_VW    = 16 * NUMBER_OF_LINE;
  localparam logic [C_CW-1:0] C_FULL    = C_CW'(FIFO_DEPTH);
  localparam logic [C_CW-1:0] C_PRIME   = C_CW'(PRIME_LEVEL);
  localparam logic [C_CW-1:0] C_CNT_ONE = C_CW'(1);
  localparam logic [C_AW-1:0] C_PTR_ONE = C_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [C_CW-1:0]   count_q, count_d, count_wr;
  logic [C_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [C_VW-1:0]   mem_q [FIFO_DEPTH];
  logic              s_ready_q, s_ready_d;
  logic              s1_valid_q;
  logic [C_VW-1:0]   s1_data_q;
  logic              dac_valid_q;
  logic [C_VW-1:0]   dac_data_q;
  logic              tx_active_q;
  logic [C_VW-1:0]   scaled;
  logic              wr_en, pop, empty, run_empty;

  assign wr_en    = s_valid && s_ready_q;
  assign empty    = (count_q == '0);
  assign count_wr = count_q + C_CW'(wr_en);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    run_empty = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (!tx_enable)               state_d = S_IDLE;
        else if (count_wr >= C_PRIME) state_d = S_RUN;
      end
      S_RUN: begin
        pop       = !empty;
        run_empty = empty;
        // Dropping tx_enable wins over re-priming on an empty FIFO.
        if (!tx_enable) state_d = S_DRAIN;
        else if (empty) state_d = S_PRIME;
      end
      S_DRAIN: begin
        pop = !empty;
        if (empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + C_CNT_ONE;
    else if (!wr_en && pop) count_d = count_q - C_CNT_ONE;
  end

  assign s_ready_d = (count_d != C_FULL) && (state_d != S_DRAIN);

  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      s_ready_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      s_ready_q   <= s_ready_d;
      tx_active_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
      if (wr_en) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      s1_valid_q  <= pop;
      s1_data_q   <= pop ? mem_q[rd_ptr_q] : '0;
      dac_valid_q <= s1_valid_q;
      dac_data_q  <= s1_valid_q ? scaled : '0;
    end
  end

  // Q1.7 gain: 25-bit product, floor-shift by 7, clamp to int16.
  for (genvar i = 0; i < NUMBER_OF_LINE; i++) begin : g_lane
    logic signed [24:0] prod;
    logic signed [17:0] shr;
    assign prod = $signed({{9{s1_data_q[16*i+15]}}, s1_data_q[16*i +: 16]})
                * $signed({17'd0, gain});
    assign shr  = 18'(prod >>> 7);
    assign scaled[16*i +: 16] = (shr[17:15] == 3'b000 || shr[17:15] == 3'b111)
                                ? shr[15:0]
                                : (shr[17] ? 16'h8000 : 16'h7FFF);
  end

`ifdef TX_UNDERFLOW_COUNT_EN
  logic [15:0] uf_cnt_q;
  always_ff @(posedge clock) begin
    if (reset)                                uf_cnt_q <= '0;
    else if (underflow && uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
  end
  assign underflow_count = uf_cnt_q;
`endif

  assign s_ready    = s_ready_q;
  assign dac_data   = dac_data_q;
  assign dac_valid  = dac_valid_q;
  assign tx_active  = tx_active_q;
  assign underflow  = run_empty && !reset;
  assign fill_level = count_q;

endmodule
`default_nettype wire

// File: doc/tx_frame_packer.md
Name: tx_frame_packer

Overview:
- Transmit-side counterpart to the receive DSP chain. Accepts parallel DAC sample vectors of NUMBER_OF_LINE x 16-bit real samples from an upstream valid/ready source, buffers them in a FIFO, and applies a per-block digital gain with saturation.
- Streams one vector per clock to the DAC lane bus under a prime/run/drain state machine.
- Sits between the transmit DSP/DUC output and the RF DAC interface.

Parameters:
- NUMBER_OF_LINE, 8, samples per vector (DAC lanes); each lane is 16-bit signed.
- FIFO_DEPTH, 16, FIFO entries (vectors); power of 2, >= 4.
- PRIME_LEVEL, 8, fill level required before streaming starts; 1..FIFO_DEPTH.

Ports:
- clock  in  1  sample clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  16*NUMBER_OF_LINE  input vector; lane i = s_data[16*(i+1)-1:16*i].
- s_valid  in  1  s_data valid.
- s_ready  out  1  block can accept s_data.
- tx_enable  in  1  level; request streaming.
- gain  in  8  unsigned gain, 128 = unity (Q1.7).
- dac_data  out  16*NUMBER_OF_LINE  scaled output vector, same lane order.
- dac_valid  out  1  dac_data carries a real sample.
- tx_active  out  1  state is RUN or DRAIN.
- underflow  out  1  one-cycle pulse on FIFO empty during RUN.
- fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: s_ready=0, dac_data=0, dac_valid=0, tx_active=0, underflow=0, fill_level=0, state=IDLE. FIFO and pipeline are flushed.
- Reset asserted mid-operation aborts immediately. Buffered data is discarded.
- Write: a transfer occurs on any edge with s_valid && s_ready.
- s_ready = !full && state != DRAIN && !reset. It is registered from next-state/next-fill.
- s_ready does not count the same-cycle pop. When the FIFO is full, no write occurs even if a pop happens that cycle.
- FSM states: IDLE, PRIME, RUN, DRAIN.
  - IDLE: no pops. tx_enable=1 -> PRIME.
  - PRIME: no pops. tx_enable=0 -> IDLE. fill_level >= PRIME_LEVEL (evaluated after that cycle's write) -> RUN.
  - RUN: pop one vector per cycle while the FIFO is non-empty.
    - FIFO empty: no pop, underflow=1 for that cycle, a zero vector is inserted (dac_valid=0 slot), next state PRIME (re-prime).
    - tx_enable=0 -> DRAIN. This takes priority over the underflow transition.
  - DRAIN: pop one per cycle until empty, then -> IDLE. No underflow pulse in DRAIN. tx_enable is ignored until IDLE is reached.
- Pipeline, fixed latency 2:
  - A vector popped at edge N appears on dac_data with dac_valid=1 after edge N+2.
  - Stage 1 registers the FIFO read word plus a valid bit.
  - Stage 2 registers the scaled result. gain is sampled at stage 2.
  - A slot without a pop propagates valid=0, and dac_data is forced to 0 for that slot.
- Arithmetic per lane:
  - p = signed16 x {1'b0,gain} gives a 25-bit signed product.
  - r = p >>> 7 (arithmetic shift, truncation toward -inf).
  - Saturate r to [-32768, 32767].
  - gain=0 -> output 0 for valid slots.
- fill_level tracks writes and pops in the same cycle. A simultaneous write and pop leaves it unchanged.
- tx_active is registered from the state.

Optional Feature:
- Macro: TX_UNDERFLOW_COUNT_EN.
- Defined: adds output port underflow_count (16-bit). It increments on every underflow pulse, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Fill and run: reset, gain=128, write 8 vectors with lane i = 0x0100*k+i (k=0..7), tx_enable=1 -> RUN entered after the 8th write. dac_data reproduces the vectors in order, dac_valid=1 for 8 consecutive cycles starting 2 cycles after the first pop. underflow pulses once when the FIFO empties, then the state is PRIME.
- Saturation: gain=255, lane value 0x7000 -> 0x7FFF. Lane 0x9000 -> 0x8000. Lane 0x0080 -> 0x00FF. Lane 0xFFFF -> 0xFFFE. gain=64, lane 0xFFFF -> 0xFFFF (-1>>>1).
- Backpressure: hold s_valid=1 with tx_enable=0 -> s_ready drops after 16 accepted writes, fill_level=16, no pops, dac_valid=0.
- Drain: in RUN with fill_level=5, drop tx_enable -> exactly 5 more valid vectors, s_ready=0 during DRAIN, no underflow pulse, then IDLE with tx_active=0.
- Reset mid-RUN: assert reset for 1 cycle with fill_level=10 -> next cycle fill_level=0, dac_data=0, dac_valid=0, state IDLE. Pipelined samples never appear.
- With TX_UNDERFLOW_COUNT_EN: force 3 underflows (write PRIME_LEVEL vectors, stall input, repeat 3 times) -> underflow_count=3. After reset -> 0.
